// File: rtl/phase_decoder.sv
// Receive side of the instr_clock/mem_clock 4-phase protocol: stage strobes, lock FSM and error counters.
// Optional hold watchdog enabled by defining PHASE_DEC_WDOG_EN.
module phase_decoder #(
  parameter int SYNC_STAGES = 0,
  parameter int LOCK_CYCLES = 2,
  parameter int CNT_W       = 16,
  parameter int WDOG_LIMIT  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_clock,
  input  logic             mem_clock,
  input  logic             clear_err,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             decode_stb,
  output logic             operand_stb,
  output logic             execute_stb,
  output logic             fetch_stb,
  output logic [CNT_W-1:0] instr_count,
  output logic             err_sticky,
  output logic [7:0]       err_count,
  output logic             err_stall
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  logic [1:0]       pair_in_s;
  logic [1:0]       pair_q, prev_q;
  logic [1:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic [3:0]       lock_cnt_inc_s;
  logic [3:0]       stb_q, stb_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             locked_q, locked_d;
  logic             err_sticky_q, err_sticky_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             trans_s, ph_valid_s, legal_s, viol_s, wdog_trip_s;
  logic [1:0]       ph_s, ph_next_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign pair_in_s = {instr_clock, mem_clock};
    end else begin : g_sync
      logic [1:0] sync_q [SYNC_STAGES];
      // Input synchroniser chain on the phase pair
      always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
        end else begin
          sync_q[0] <= {instr_clock, mem_clock};
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign pair_in_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Map a pair transition to a phase; 10 is resolved by the pair it came from
  always_comb begin
    trans_s    = (pair_q != prev_q);
    ph_valid_s = 1'b0;
    ph_s       = 2'd0;
    ph_next_s  = phase_q + 2'd1;
    case ({prev_q, pair_q})
      4'b0010: begin ph_valid_s = 1'b1; ph_s = 2'd0; end
      4'b1011: begin ph_valid_s = 1'b1; ph_s = 2'd1; end
      4'b1110: begin ph_valid_s = 1'b1; ph_s = 2'd2; end
      4'b1000: begin ph_valid_s = 1'b1; ph_s = 2'd3; end
      default: begin ph_valid_s = 1'b0; ph_s = 2'd0; end
    endcase
    if (!trans_s) begin
      legal_s = 1'b1;
    end else begin
      legal_s = ph_valid_s && (ph_s == ph_next_s);
    end
  end

`ifdef PHASE_DEC_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 2);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              err_stall_q, err_stall_d;

  // Count clocks the pair has held its value while locked (saturating)
  always_comb begin
    if (state_q != ST_LOCKED) begin
      wdog_cnt_d = '0;
    end else if (trans_s) begin
      wdog_cnt_d = WDOG_W'(1);
    end else if (wdog_cnt_q == WDOG_MAX) begin
      wdog_cnt_d = WDOG_MAX;
    end else begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
    if (wdog_trip_s) begin
      err_stall_d = 1'b1;
    end else if (clear_err) begin
      err_stall_d = 1'b0;
    end else begin
      err_stall_d = err_stall_q;
    end
  end

  assign wdog_trip_s = (state_q == ST_LOCKED) && (wdog_cnt_d == WDOG_MAX);

  // Watchdog state registers
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wdog_cnt_q  <= '0;
      err_stall_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      err_stall_q <= err_stall_d;
    end
  end

  assign err_stall = err_stall_q;
`else
  assign wdog_trip_s = 1'b0;
  assign err_stall   = 1'b0;
`endif

  // Lock FSM, strobe generation and counters
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    lock_cnt_d     = lock_cnt_q;
    lock_cnt_inc_s = lock_cnt_q + 4'd1;
    stb_d          = 4'b0000;
    instr_cnt_d    = instr_cnt_q;
    viol_s         = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (pair_q == 2'b00) begin
          state_d    = ST_ALIGN;
          phase_d    = 2'd3;
          lock_cnt_d = 4'd0;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_ALIGN: begin
        if (!legal_s) begin
          state_d = ST_SEARCH;
        end else if (trans_s) begin
          phase_d = ph_s;
          if (ph_s == 2'd3) begin
            lock_cnt_d = lock_cnt_inc_s;
            if (lock_cnt_inc_s == 4'(LOCK_CYCLES)) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_ALIGN;
            end
          end else begin
            lock_cnt_d = lock_cnt_q;
          end
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_LOCKED: begin
        if (!legal_s || wdog_trip_s) begin
          state_d = ST_FAULT;
          viol_s  = 1'b1;
        end else if (trans_s) begin
          phase_d      = ph_s;
          stb_d[ph_s]  = 1'b1;
          if (ph_s == 2'd3) begin
            instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            instr_cnt_d = instr_cnt_q;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_FAULT: begin
        state_d    = ST_SEARCH;
        lock_cnt_d = 4'd0;
      end
      default: begin
        state_d    = ST_SEARCH;
        lock_cnt_d = 4'd0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);

    // A violation in the same clock as clear_err restarts the count at one
    if (viol_s) begin
      err_sticky_d = 1'b1;
      if (clear_err) begin
        err_count_d = 8'd1;
      end else if (err_count_q == 8'hFF) begin
        err_count_d = 8'hFF;
      end else begin
        err_count_d = err_count_q + 8'd1;
      end
    end else if (clear_err) begin
      err_sticky_d = 1'b0;
      err_count_d  = 8'd0;
    end else begin
      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
    end
  end

  // Pair pipeline and FSM state registers
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      pair_q       <= 2'b00;
      prev_q       <= 2'b00;
      state_q      <= ST_SEARCH;
      phase_q      <= 2'd0;
      lock_cnt_q   <= 4'd0;
      stb_q        <= 4'b0000;
      instr_cnt_q  <= '0;
      locked_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      pair_q       <= pair_in_s;
      prev_q       <= pair_q;
      state_q      <= state_d;
      phase_q      <= phase_d;
      lock_cnt_q   <= lock_cnt_d;
      stb_q        <= stb_d;
      instr_cnt_q  <= instr_cnt_d;
      locked_q     <= locked_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked      = locked_q;
  assign phase       = phase_q;
  assign decode_stb  = stb_q[0];
  assign operand_stb = stb_q[1];
  assign execute_stb = stb_q[2];
  assign fetch_stb   = stb_q[3];
  assign instr_count = instr_cnt_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_phase_decoder.sv
// Scoreboard bench for phase_decoder: a 16-bit counter instance and a 4-bit counter instance share stimulus.
`timescale 1ns/1ps
module tb_phase_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        instr_clock = 1'b0;
  logic        mem_clock = 1'b0;
  logic        clear_err = 1'b0;

  logic        locked, decode_stb, operand_stb, execute_stb, fetch_stb, err_sticky, err_stall;
  logic [1:0]  phase;
  logic [15:0] instr_count;
  logic [7:0]  err_count;

  logic        locked_w, decode_stb_w, operand_stb_w, execute_stb_w, fetch_stb_w, err_sticky_w, err_stall_w;
  logic [1:0]  phase_w;
  logic [3:0]  instr_count_w;
  logic [7:0]  err_count_w;

  phase_decoder #(.SYNC_STAGES(0), .LOCK_CYCLES(2), .CNT_W(16), .WDOG_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n), .instr_clock(instr_clock), .mem_clock(mem_clock),
    .clear_err(clear_err), .locked(locked), .phase(phase), .decode_stb(decode_stb),
    .operand_stb(operand_stb), .execute_stb(execute_stb), .fetch_stb(fetch_stb),
    .instr_count(instr_count), .err_sticky(err_sticky), .err_count(err_count), .err_stall(err_stall)
  );

  phase_decoder #(.SYNC_STAGES(0), .LOCK_CYCLES(2), .CNT_W(4), .WDOG_LIMIT(8)) dut_w (
    .clk(clk), .reset_n(reset_n), .instr_clock(instr_clock), .mem_clock(mem_clock),
    .clear_err(clear_err), .locked(locked_w), .phase(phase_w), .decode_stb(decode_stb_w),
    .operand_stb(operand_stb_w), .execute_stb(execute_stb_w), .fetch_stb(fetch_stb_w),
    .instr_count(instr_count_w), .err_sticky(err_sticky_w), .err_count(err_count_w), .err_stall(err_stall_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] stb;
    int         due;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_instr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every cycle the strobes must match the due entry, or be all zero
  always @(posedge clk) begin : mon
    exp_t       e;
    logic [3:0] want;
    logic [1:0] want_ph;
    #1;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      errors++;
      $display("FAIL stale_exp: strobe %b due cycle %0d never matched (now %0d)", e.stb, e.due, cyc);
    end
    want = 4'b0000;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      want = e.stb;
    end
    checks++;
    if ({fetch_stb, execute_stb, operand_stb, decode_stb} !== want) begin
      errors++;
      $display("FAIL stb cyc %0d: got %b want %b", cyc, {fetch_stb, execute_stb, operand_stb, decode_stb}, want);
    end
    checks++;
    if ({fetch_stb_w, execute_stb_w, operand_stb_w, decode_stb_w} !== want) begin
      errors++;
      $display("FAIL stb_w cyc %0d: got %b want %b", cyc, {fetch_stb_w, execute_stb_w, operand_stb_w, decode_stb_w}, want);
    end
    if (want != 4'b0000) begin
      case (want)
        4'b0001: want_ph = 2'd0;
        4'b0010: want_ph = 2'd1;
        4'b0100: want_ph = 2'd2;
        default: want_ph = 2'd3;
      endcase
      checks++;
      if (phase !== want_ph) begin
        errors++;
        $display("FAIL phase cyc %0d: got %0d want %0d", cyc, phase, want_ph);
      end
    end
  end

  task automatic step(input logic [1:0] p, input logic [3:0] e, input logic clr);
    exp_t x;
    @(negedge clk);
    {instr_clock, mem_clock} = p;
    clear_err = clr;
    if (e != 4'b0000) begin
      x.stb = e;
      x.due = cyc + 2;
      sbq.push_back(x);
    end
    if (e[3]) exp_instr++;
  endtask

  task automatic run_cycles(input int n, input logic en);
    for (int i = 0; i < n; i++) begin
      step(2'b10, en ? 4'b0001 : 4'b0000, 1'b0);
      step(2'b11, en ? 4'b0010 : 4'b0000, 1'b0);
      step(2'b10, en ? 4'b0100 : 4'b0000, 1'b0);
      step(2'b00, en ? 4'b1000 : 4'b0000, 1'b0);
    end
  endtask

  task automatic acquire_lock();
    repeat (4) step(2'b00, 4'b0000, 1'b0);
    run_cycles(2, 1'b0);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    {instr_clock, mem_clock} = 2'b00;
    clear_err = 1'b0;
    sbq.delete();
    exp_instr = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({locked, phase, decode_stb, operand_stb, execute_stb, fetch_stb, err_sticky, err_stall} !== 9'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0", {locked, phase, decode_stb, operand_stb, execute_stb, fetch_stb, err_sticky, err_stall});
    end
    checks++;
    if (instr_count !== 16'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: instr %0d err %0d want 0 0", instr_count, err_count);
    end
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic test_lock();
    repeat (4) step(2'b00, 4'b0000, 1'b0);
    run_cycles(2, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: got %b want 0", locked);
    end
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_2: got %b want 1", locked);
    end
    run_cycles(1, 1'b1);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (instr_count !== 16'd1 || instr_count_w !== 4'd1) begin
      errors++;
      $display("FAIL count_first: got %0d/%0d want 1/1", instr_count, instr_count_w);
    end
  endtask

  task automatic test_count();
    do_reset();
    acquire_lock();
    run_cycles(100, 1'b1);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (instr_count !== exp_instr[15:0] || exp_instr != 100) begin
      errors++;
      $display("FAIL count_100: got %0d want %0d", instr_count, exp_instr);
    end
    checks++;
    if (instr_count_w !== 4'd4) begin
      errors++;
      $display("FAIL count_w_100: got %0d want 4", instr_count_w);
    end
    do_reset();
    acquire_lock();
    run_cycles(17, 1'b1);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (instr_count_w !== 4'd1) begin
      errors++;
      $display("FAIL count_wrap: got %0d want 1", instr_count_w);
    end
    checks++;
    if (instr_count !== 16'd17) begin
      errors++;
      $display("FAIL count_17: got %0d want 17", instr_count);
    end
  endtask

  task automatic test_fault();
    step(2'b11, 4'b0000, 1'b0);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (err_sticky !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL fault: sticky %b cnt %0d locked %b want 1 1 0", err_sticky, err_count, locked);
    end
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    run_cycles(2, 1'b0);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock: got %b want 1", locked);
    end
    run_cycles(1, 1'b1);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("FAIL fault_clean: err_count %0d want 1", err_count);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      step(2'b11, 4'b0000, 1'b0);
      repeat (4) step(2'b00, 4'b0000, 1'b0);
      run_cycles(2, 1'b0);
      repeat (2) step(2'b00, 4'b0000, 1'b0);
    end
    checks++;
    if (err_count !== 8'd255 || err_count_w !== 8'd255 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got %0d/%0d sticky %b want 255/255 1", err_count, err_count_w, err_sticky);
    end
    step(2'b11, 4'b0000, 1'b0);
    step(2'b00, 4'b0000, 1'b1);
    step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (err_count !== 8'd1 || err_sticky !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_fault: cnt %0d sticky %b locked %b want 1 1 0", err_count, err_sticky, locked);
    end
    step(2'b00, 4'b0000, 1'b1);
    step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (err_count !== 8'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL clear: cnt %0d sticky %b want 0 0", err_count, err_sticky);
    end
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    run_cycles(2, 1'b0);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(2'b10, 4'b0001, 1'b0);
    step(2'b11, 4'b0010, 1'b0);
    step(2'b10, 4'b0000, 1'b0);
    @(negedge clk);
    checks++;
    if (operand_stb !== 1'b1) begin
      errors++;
      $display("FAIL mid_operand: got %b want 1", operand_stb);
    end
    reset_n = 1'b1;
    sbq.delete();
    exp_instr = 0;
    #1;
    checks++;
    if ({locked, phase, decode_stb, operand_stb, execute_stb, fetch_stb, err_sticky, err_stall} !== 9'd0
        || instr_count !== 16'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: flags %b instr %0d err %0d want all 0",
               {locked, phase, decode_stb, operand_stb, execute_stb, fetch_stb, err_sticky, err_stall},
               instr_count, err_count);
    end
    {instr_clock, mem_clock} = 2'b00;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    repeat (50) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_sticky !== 1'b0 || err_count !== 8'd0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL hold_00: locked %b sticky %b err %0d instr %0d want 0", locked, err_sticky, err_count, instr_count);
    end
  endtask

  task automatic test_wdog();
    run_cycles(2, 1'b0);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    // eight clocks of 11 is still tolerated
    step(2'b10, 4'b0001, 1'b0);
    step(2'b11, 4'b0010, 1'b0);
    repeat (7) step(2'b11, 4'b0000, 1'b0);
    step(2'b10, 4'b0100, 1'b0);
    step(2'b00, 4'b1000, 1'b0);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (err_count !== 8'd0 || locked !== 1'b1 || err_stall !== 1'b0) begin
      errors++;
      $display("FAIL wdog_hold8: err %0d locked %b stall %b want 0 1 0", err_count, locked, err_stall);
    end
    step(2'b10, 4'b0001, 1'b0);
    step(2'b11, 4'b0010, 1'b0);
    repeat (8) step(2'b11, 4'b0000, 1'b0);
`ifdef PHASE_DEC_WDOG_EN
    step(2'b10, 4'b0000, 1'b0);
    step(2'b00, 4'b0000, 1'b0);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (err_stall !== 1'b1 || err_count !== 8'd1 || err_sticky !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL wdog_trip: stall %b err %0d sticky %b locked %b want 1 1 1 0", err_stall, err_count, err_sticky, locked);
    end
    step(2'b00, 4'b0000, 1'b1);
    step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (err_stall !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL wdog_clear: stall %b err %0d want 0 0", err_stall, err_count);
    end
`else
    step(2'b10, 4'b0100, 1'b0);
    step(2'b00, 4'b1000, 1'b0);
    repeat (2) step(2'b00, 4'b0000, 1'b0);
    checks++;
    if (err_stall !== 1'b0 || err_count !== 8'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL hold9_nowdog: stall %b err %0d locked %b want 0 0 1", err_stall, err_count, locked);
    end
`endif
    checks++;
    if (instr_count !== exp_instr[15:0]) begin
      errors++;
      $display("FAIL wdog_count: got %0d want %0d", instr_count, exp_instr);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_count();
    test_fault();
    test_saturate();
    test_reset_mid();
    test_wdog();
    repeat (4) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected strobes never seen", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete within 1 ms");
    $fatal(1, "timeout");
  end

endmodule
